bcd_scan_display: RTL and testbench

//  Downstream stage of the 4-bit units counter. Consumes the counter's units digit and carry-out.

---
 rtl/bcd_disp_pkg.sv | 32 +++
 rtl/seg7_decode.sv | 28 ++
 rtl/bcd_scan_display.sv | 113 +++++++++++
 tb/tb_bcd_scan_display.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the bcd_scan_display slice.
//   - 7-segment patterns in active-high form, bit order {g,f,e,d,c,b,a}
//   - digit-select encoding used by the scan logic
//   - polarity helpers that map active-high values onto the pin polarity
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic {
    DIG_UNITS = 1'b0,
    DIG_TENS  = 1'b1
  } dig_sel_e;

  function automatic logic [6:0] apply_pol_seg(input logic [6:0] v, input logic active_low);
    return active_low ? ~v : v;
  endfunction

  function automatic logic [1:0] apply_pol_an(input logic [1:0] v, input logic active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder.
//   bcd_i [3:0] : digit value; 10..15 produce a blank pattern
//   seg_o [6:0] : active-high segments {g,f,e,d,c,b,a}
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Tens stage and 2-digit multiplexed 7-segment driver fed by a BCD units counter.
//   CLK          : system clock, rising edge
//   MR           : asynchronous active-low master reset
//   CI           : carry from the units counter (units wraps 9->0 this edge)
//   D_UNITS[3:0] : units digit from the units counter
//   HOLD         : freeze the displayed digits; counting continues
//   SEG[6:0]     : registered segments {g,f,e,d,c,b,a}
//   AN[1:0]      : registered digit enables, AN[0]=units, AN[1]=tens
//   OV           : registered sticky tens overflow
// Parameters: SCAN_DIV (cycles per digit, >=2), TENS_MAX (last tens value),
//   SEG_ACTIVE_LOW (1: SEG/AN active-low, 0: active-high).
// Build option: define LEADING_ZERO_BLANK_EN to blank the tens digit when it is 0.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 16,
  parameter int unsigned TENS_MAX       = 9,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic       CLK,
  input  logic       MR,
  input  logic       CI,
  input  logic [3:0] D_UNITS,
  input  logic       HOLD,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       OV
);

  localparam int unsigned      DIV_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       TENS_LAST = 4'(TENS_MAX);
  localparam logic             POL_LOW   = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]       SEG_RST   = apply_pol_seg(SEG_OFF, POL_LOW);
  localparam logic [1:0]       AN_RST    = apply_pol_an(2'b00, POL_LOW);

  logic [3:0]       tens_q,  tens_d;
  logic             ov_q,    ov_d;
  logic [7:0]       latch_q, latch_d;
  logic [DIV_W-1:0] div_q,   div_d;
  dig_sel_e         sel_q,   sel_d;
  logic [6:0]       seg_q,   seg_d;
  logic [1:0]       an_q,    an_d;

  logic [3:0] digit;
  logic [6:0] pattern;
  logic       blank;

  // Single decoder shared by both digits: mux first, then decode.
  seg7_decode u_dec (
    .bcd_i (digit),
    .seg_o (pattern)
  );

  always_comb begin
    tens_d  = tens_q;
    ov_d    = ov_q;
    latch_d = latch_q;
    div_d   = div_q + DIV_W'(1);
    sel_d   = sel_q;

    if (CI) begin
      if (tens_q == TENS_LAST) begin
        tens_d = '0;
        ov_d   = 1'b1;
      end else begin
        tens_d = tens_q + 4'd1;
      end
    end

    // Latches the pre-increment tens value alongside the current units digit.
    if (!HOLD) latch_d = {tens_q, D_UNITS};

    if (div_q == DIV_LAST) begin
      div_d = '0;
      sel_d = (sel_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
    end

    digit = (sel_q == DIG_TENS) ? latch_q[7:4] : latch_q[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    blank = (sel_q == DIG_TENS) && (latch_q[7:4] == 4'd0);
`else
    blank = 1'b0;
`endif
    seg_d = apply_pol_seg(blank ? SEG_OFF : pattern, POL_LOW);
    an_d  = apply_pol_an((sel_q == DIG_TENS) ? 2'b10 : 2'b01, POL_LOW);
  end

  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      tens_q  <= '0;
      ov_q    <= 1'b0;
      latch_q <= '0;
      div_q   <= '0;
      sel_q   <= DIG_UNITS;
      seg_q   <= SEG_RST;
      an_q    <= AN_RST;
    end else begin
      tens_q  <= tens_d;
      ov_q    <= ov_d;
      latch_q <= latch_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign OV  = ov_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
module tb_bcd_scan_display;

  localparam int SCAN = 4;

  logic       CLK = 1'b0;
  logic       MR;
  logic       CI;
  logic [3:0] D_UNITS;
  logic       HOLD;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic       OV;

  int nchk  = 0;
  int nfail = 0;

  // Reference model state
  int m_tens, m_ov, m_lat_t, m_lat_u, m_edges;

  bcd_scan_display #(.SCAN_DIV(SCAN), .TENS_MAX(9), .SEG_ACTIVE_LOW(1)) dut (
    .CLK(CLK), .MR(MR), .CI(CI), .D_UNITS(D_UNITS), .HOLD(HOLD),
    .SEG(SEG), .AN(AN), .OV(OV)
  );

  always #5 CLK = ~CLK;

  // Active-low pin value for a digit shown in a given slot.
  function automatic logic [6:0] exp_seg(input int d, input bit tens_slot);
    logic [6:0] pat [10];
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d > 9) return 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    if (tens_slot && d == 0) return 7'h7F;
`endif
    return ~pat[d];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int cur_slot();
    return ((m_edges - 1) / SCAN) % 2;
  endfunction

  task automatic model_reset();
    m_tens = 0; m_ov = 0; m_lat_t = 0; m_lat_u = 0; m_edges = 0;
  endtask

  // One clock edge: model predicts outputs from pre-edge state, then updates.
  task automatic tick();
    int slot, d;
    logic [6:0] es;
    logic [1:0] ea;
    @(posedge CLK);
    m_edges++;
    slot = cur_slot();
    d    = slot ? m_lat_t : m_lat_u;
    es   = exp_seg(d, slot != 0);
    ea   = slot ? 2'b01 : 2'b10;
    if (!HOLD) begin m_lat_t = m_tens; m_lat_u = int'(D_UNITS); end
    if (CI) begin
      if (m_tens == 9) begin m_tens = 0; m_ov = 1; end
      else m_tens++;
    end
    #1;
    chk("seg", {1'b0, SEG}, {1'b0, es});
    chk("an", {6'd0, AN}, {6'd0, ea});
    chk("ov", {7'd0, OV}, 8'(m_ov));
  endtask

  task automatic tick_to(input int slot);
    for (int i = 0; i < 2 * SCAN + 1; i++) begin
      tick();
      if (cur_slot() == slot) return;
    end
  endtask

  task automatic ci_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      CI = 1'b1; tick();
      CI = 1'b0; tick();
    end
  endtask

  initial begin
    MR = 1'b0; CI = 1'b0; D_UNITS = 4'd0; HOLD = 1'b0;
    model_reset();

    // 1. reset state
    #50;
    chk("rst_seg", {1'b0, SEG}, 8'h7F);
    chk("rst_an", {6'd0, AN}, 8'h03);
    chk("rst_ov", {7'd0, OV}, 8'h00);
    #50 MR = 1'b1;
    for (int i = 0; i < 2 * SCAN; i++) tick();

    // 2. units 7, tens 0
    D_UNITS = 4'd7;
    tick();
    tick_to(0);
    chk("units7", {1'b0, SEG}, 8'h78);
    tick_to(1);
`ifdef LEADING_ZERO_BLANK_EN
    chk("tens0_blank", {1'b0, SEG}, 8'h7F);
`else
    chk("tens0", {1'b0, SEG}, 8'h40);
`endif

    // 3. three carries -> tens 3
    ci_pulses(3);
    tick_to(0);
    tick_to(1);
    chk("tens3", {1'b0, SEG}, 8'h30);
    chk("ov_after3", {7'd0, OV}, 8'h00);

    // 5. freeze "42", count 5 more, change units, release -> "92"
    ci_pulses(1);
    D_UNITS = 4'd2;
    tick();
    HOLD = 1'b1;
    ci_pulses(5);
    D_UNITS = 4'd6; tick(); D_UNITS = 4'd2;
    tick_to(0);
    chk("hold_units2", {1'b0, SEG}, 8'h24);
    tick_to(1);
    chk("hold_tens4", {1'b0, SEG}, 8'h19);
    HOLD = 1'b0;
    tick_to(0);
    tick_to(1);
    chk("rel_tens9", {1'b0, SEG}, 8'h10);

    // 6a. out-of-range units digit
    D_UNITS = 4'hC;
    tick();
    tick_to(0);
    chk("units_c", {1'b0, SEG}, 8'h7F);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      D_UNITS = 4'($urandom_range(0, 15));
      CI      = ($urandom_range(0, 3) == 0);
      HOLD    = ($urandom_range(0, 5) == 0);
      tick();
    end
    CI = 1'b0;

    // 6b. asynchronous reset mid-scan, while holding
    HOLD = 1'b1;
    tick(); tick();
    MR = 1'b0;
    #1;
    chk("async_seg", {1'b0, SEG}, 8'h7F);
    chk("async_an", {6'd0, AN}, 8'h03);
    chk("async_ov", {7'd0, OV}, 8'h00);
    model_reset();
    HOLD = 1'b0; D_UNITS = 4'd5;
    #20 MR = 1'b1;
    tick();
    chk("post_rst_an", {6'd0, AN}, 8'h02);

    // 4. overflow and stickiness
    ci_pulses(9);
    chk("ov_at9", {7'd0, OV}, 8'h00);
    ci_pulses(1);
    chk("ov_set", {7'd0, OV}, 8'h01);
    tick_to(1);
    tick_to(0);
    tick_to(1);
`ifdef LEADING_ZERO_BLANK_EN
    chk("wrap_tens0", {1'b0, SEG}, 8'h7F);
`else
    chk("wrap_tens0", {1'b0, SEG}, 8'h40);
`endif
    ci_pulses(20);
    chk("ov_sticky", {7'd0, OV}, 8'h01);
    MR = 1'b0;
    #1;
    chk("ov_clr", {7'd0, OV}, 8'h00);
    #20;

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
